// File: rtl/ldl_idx_dec_pkg.sv
// Shared constants and types for the LDL indexed event decoder.
// The stall counter width and its saturation value live here so other LDL blocks agree on them.
package LDL_pkg;

  localparam int LDL_STALL_CNT_W = 16;
  localparam logic [LDL_STALL_CNT_W-1:0] LDL_STALL_CNT_MAX = '1;

  // What the staged entry does in the current cycle.
  typedef enum logic [1:0] {
    CMT_NONE,
    CMT_SET,
    CMT_OOR,
    CMT_STALL
  } cmt_e;

  function automatic logic [LDL_STALL_CNT_W-1:0] sat_inc(
    input logic [LDL_STALL_CNT_W-1:0] v
  );
    return (v == LDL_STALL_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ldl_idx_dec_bin2oh.sv
// Combinational binary index to one-hot decode.
// Indices at or above WIDTH decode to all-zero.
module LDL_bin2oh #(
  parameter int WIDTH = 4,
  localparam int AW = $clog2(WIDTH)
) (
  input  logic [AW-1:0]    idx,
  output logic [WIDTH-1:0] oh
);

  always_comb begin
    oh = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (idx == AW'(i)) oh[i] = 1'b1;
    end
  end

endmodule

// File: rtl/ldl_idx_dec.sv
// Indexed event decoder: accepted indices set sticky pending bits that the consumer clears.
// Optional stall-cycle counter enabled by defining LDL_IDX_DEC_STALL_CNT_EN.
module ldl_idx_dec
  import LDL_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int AW = $clog2(WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AW-1:0]              x_idx,
  input  logic                       x_valid,
  output logic                       x_ready,
  input  logic [WIDTH-1:0]           clr,
  output logic [WIDTH-1:0]           y,
  output logic [WIDTH-1:0]           y_pulse,
  output logic                       valid,
  output logic                       err,
  output logic [LDL_STALL_CNT_W-1:0] stall_cnt
);

  logic             s_vld;
  logic [AW-1:0]    s_idx;
  logic [WIDTH-1:0] s_oh;
  logic             s_in_range;
  logic             s_go;
  logic             take;
  cmt_e             cmt;

  LDL_bin2oh #(.WIDTH(WIDTH)) u_dec (
    .idx (s_idx),
    .oh  (s_oh)
  );

  assign s_in_range = ({1'b0, s_idx} < (AW+1)'(WIDTH));

  // A staged entry waits only while its bit is pending and not being cleared this cycle.
  always_comb begin
    cmt = CMT_NONE;
    if (s_vld) begin
      if (!s_in_range)                cmt = CMT_OOR;
      else if (|(s_oh & y & ~clr))    cmt = CMT_STALL;
      else                            cmt = CMT_SET;
    end
  end

  assign s_go    = (cmt == CMT_SET) || (cmt == CMT_OOR);
  assign x_ready = rst || !s_vld || s_go;
  assign take    = x_valid && x_ready;
  assign valid   = |y;

  // Set wins over clear: the committing bit is ORed in after the clear mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_vld   <= 1'b0;
      s_idx   <= '0;
      y       <= '0;
      y_pulse <= '0;
      err     <= 1'b0;
    end else begin
      y       <= (y & ~clr) | ((cmt == CMT_SET) ? s_oh : '0);
      y_pulse <= (cmt == CMT_SET) ? s_oh : '0;
      if (cmt == CMT_OOR) err <= 1'b1;
      if (take) begin
        s_vld <= 1'b1;
        s_idx <= x_idx;
      end else if (s_go) begin
        s_vld <= 1'b0;
      end
    end
  end

`ifdef LDL_IDX_DEC_STALL_CNT_EN
  logic [LDL_STALL_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                    cnt_q <= '0;
    else if (cmt == CMT_STALL)  cnt_q <= sat_inc(cnt_q);
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/ldl_idx_dec.md
# LDL_idx_dec

Indexed event decoder with pending register: the receive-side counterpart of the library priority encoder. It accepts binary indices over a valid/ready handshake and decodes each to a one-hot bit. Each accepted index sets a bit in a sticky pending vector, which a downstream consumer clears bit-by-bit. It sits between an index producer (encoder, arbiter, interrupt source) and per-channel consumers.

## Interface
- WIDTH, 4, number of channels / pending bits (≥2, need not be power of two)
- AW (localparam), $clog2(WIDTH), index width
- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- x_idx  in  AW  channel index
- x_valid  in  1  x_idx valid
- x_ready  out  1  block can accept x_idx this cycle
- clr  in  WIDTH  per-bit clear of pending vector
- y  out  WIDTH  pending vector (registered)
- y_pulse  out  WIDTH  one-hot strobe, one cycle, on each set of a pending bit
- valid  out  1  |y
- err  out  1  sticky: an out-of-range index (≥WIDTH) was accepted
- stall_cnt  out  16  saturating stall-cycle count (see Configuration)

## Operation
- Handshake: transfer when x_valid && x_ready. x_idx is don't-care while x_valid is low.
- One-entry stage register holds s_vld and s_idx.
- Commit condition s_go = s_vld && (s_idx ≥ WIDTH || !y[s_idx] || clr[s_idx]).
- x_ready = !s_vld || s_go. This is combinational from state and clr only, never from x_valid.
- On s_go with s_idx < WIDTH:
  - y[s_idx] ← 1 next edge.
  - y_pulse ← onehot(s_idx) for exactly one cycle.
- On s_go with s_idx ≥ WIDTH:
  - No y or y_pulse change.
  - err ← 1, held until rst.
- Collision (target bit already pending and not cleared this cycle):
  - Entry stalls in the stage register and x_ready stays low.
  - Entry commits in the cycle the consumer asserts clr for that bit.
- Clear: y ← y & ~clr, except that a bit being set by s_go in the same cycle ends up 1 (set wins over clear).
- Bits not addressed by s_go follow clr only.
- Reset values: y=0, y_pulse=0, s_vld=0, err=0, stall_cnt=0. During rst, x_ready=1.
  - Any entry in flight is discarded.
  - Handshakes presented while rst is high are lost.

## Timing
- Latency: accept at edge N, commit evaluated in cycle after N.
  - If no collision: y bit and y_pulse visible after edge N+1.
  - valid follows y the same cycle (combinational OR).
- Throughput: one index per cycle with no collisions; x_ready stays high back-to-back.
- Stall release: clr[k] high in cycle C with stalled s_idx=k gives x_ready=1 in cycle C. y[k] stays 1 (re-set) and y_pulse[k]=1 after edge C.
- Same index twice back-to-back with no clr:
  - First index commits.
  - Second stalls.
  - Third is not accepted.

## Configuration
- LDL_IDX_DEC_STALL_CNT_EN defined: stall_cnt increments each cycle with s_vld && !s_go.
  - Saturates at 16'hFFFF and does not wrap.
  - Cleared by rst only.
- Undefined: no counter flops; stall_cnt tied to 0.

## Structure
- Shared package LDL_pkg holds the stall counter width constant LDL_STALL_CNT_W = 16 and the saturating max value.
- Sub-module LDL_bin2oh (parameter WIDTH) does the combinational index→one-hot decode. Its output is all-zero for out-of-range indices. It is instantiated once on s_idx.

## Test plan
- Reset, WIDTH=4: after rst, y=0, y_pulse=0, valid=0, err=0, x_ready=1, stall_cnt=0.
- Stream indices 0,1,2,3 on consecutive cycles, clr=0: x_ready always 1; y_pulse =0001,0010,0100,1000 on successive cycles; final y=1111.
- Collision: send 2, then 2, then 1; hold clr=0 for 5 cycles, then clr=0100 for one cycle.
  - Second 2 stalls and x_ready=0 for 5 cycles.
  - stall_cnt=5 with macro defined, 0 without.
  - On the clr cycle: x_ready=1, then y_pulse=0100 and y[2]=1; index 1 then commits next.
- Set/clear race: with y=0010, send idx 3 while clr=1000 in the commit cycle → y=1010. Separately, clr=0010 with no commit → y=0000, valid=0.
- Out of range, WIDTH=5: send idx 6 → accepted, no stall, y unchanged, err=1 sticky until rst.
- Reset mid-stall: with an entry stalled, assert rst for one cycle → s_vld dropped, x_ready=1, no y_pulse afterwards.
